// File: rtl/rf_wport_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wport_sched
//  Description : Write-port scheduler and scoreboard for the 32x32 register
//                file. Shares the single write port between the in-order
//                writeback stage (strict priority) and a 2-entry buffer of
//                out-of-order multicycle results, tracks pending multicycle
//                destinations, and stalls decode on RAW/WAW hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_sched #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_wr,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic        i_mc_valid,
    output logic        o_mc_ready,
    input  logic [4:0]  i_mc_addr,
    input  logic [31:0] i_mc_data,
    input  logic        i_iss_valid,
    input  logic [4:0]  i_iss_addr,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_wr,
    input  logic [4:0]  i_id_rd,
    output logic        o_stall,
    output logic        o_rf_wr,
    output logic [4:0]  o_rf_addr,
    output logic [31:0] o_rf_data,
    output logic        o_err
);

    localparam logic [1:0] c_CNT_FULL = 2'(FIFO_DEPTH);

    // Scoreboard and result buffer state
    logic [31:0] r_pend;
    logic [4:0]  r_fifo_addr [0:1];
    logic [31:0] r_fifo_data [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_err;

    logic        w_full;
    logic        w_empty;
    logic        w_wb_sel;
    logic        w_push;
    logic        w_pop;
    logic        w_set;
    logic        w_pend_any;
    logic        w_pend_multi;
    logic        w_outstanding_ge2;
    logic        w_stall;
    logic [4:0]  w_head_addr;
    logic [31:0] w_head_data;
    logic [31:0] w_pend_next;

    assign w_full      = (r_count == c_CNT_FULL);
    assign w_empty     = (r_count == 2'd0);
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Ready depends only on registered occupancy, never on a same-cycle pop
    assign o_mc_ready  = !w_full;

    // Writeback owns the port whenever it writes a real register
    assign w_wb_sel    = i_wb_wr && (i_wb_addr != 5'd0);
    assign w_pop       = !w_wb_sel && !w_empty;
    assign w_push      = i_mc_valid && !w_full && (i_mc_addr != 5'd0);

    // "At least two outstanding" = buffered entries + pending bits >= 2;
    // x & (x-1) is non-zero exactly when two or more pend bits are set
    assign w_pend_any        = |r_pend;
    assign w_pend_multi      = |(r_pend & (r_pend - 32'd1));
    assign w_outstanding_ge2 = (r_count == 2'd2)
                            || ((r_count == 2'd1) && w_pend_any)
                            || w_pend_multi;

    // Hazard detection from registered state only
    always_comb begin
        w_stall = 1'b0;
        if ((i_id_rs != 5'd0) && r_pend[i_id_rs])
            w_stall = 1'b1;
        if ((i_id_rt != 5'd0) && r_pend[i_id_rt])
            w_stall = 1'b1;
        if (i_id_wr && (i_id_rd != 5'd0) && r_pend[i_id_rd])
            w_stall = 1'b1;
        if (i_iss_valid && (i_iss_addr != 5'd0) && r_pend[i_iss_addr])
            w_stall = 1'b1;
        if (i_iss_valid && w_outstanding_ge2)
            w_stall = 1'b1;
    end

    assign o_stall = w_stall;
    assign w_set   = i_iss_valid && !w_stall && (i_iss_addr != 5'd0);

    // Write-port arbitration: writeback first, then buffer head, else idle
    always_comb begin
        o_rf_wr   = 1'b0;
        o_rf_addr = 5'd0;
        o_rf_data = 32'd0;
        if (w_wb_sel) begin
            o_rf_wr   = 1'b1;
            o_rf_addr = i_wb_addr;
            o_rf_data = i_wb_data;
        end else if (!w_empty) begin
            o_rf_wr   = 1'b1;
            o_rf_addr = w_head_addr;
            o_rf_data = w_head_data;
        end
    end

    // Next scoreboard: clear the register being written from the buffer, then set a new issue
    always_comb begin
        w_pend_next = r_pend;
        if (w_pop)
            w_pend_next[w_head_addr] = 1'b0;
        if (w_set)
            w_pend_next[i_iss_addr] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_pend <= '0;
        else
            r_pend <= w_pend_next;
    end

    // Result buffer: pointers, occupancy and entry storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
            r_fifo_addr[0] <= 5'd0;
            r_fifo_addr[1] <= 5'd0;
            r_fifo_data[0] <= 32'd0;
            r_fifo_data[1] <= 32'd0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= i_mc_addr;
                r_fifo_data[r_wr_ptr] <= i_mc_data;
                r_wr_ptr              <= !r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= !r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error: a result accepted for a register that was not pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_err <= 1'b0;
        else if (w_push && !r_pend[i_mc_addr])
            r_err <= 1'b1;
    end

    assign o_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wport_sched
//  Description : Self-checking bench for rf_wport_sched. Directed scenarios
//                followed by randomized traffic, all compared every cycle
//                against a queue/array reference model of the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wport_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wb_wr;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_mc_valid;
    logic        o_mc_ready;
    logic [4:0]  i_mc_addr;
    logic [31:0] i_mc_data;
    logic        i_iss_valid;
    logic [4:0]  i_iss_addr;
    logic [4:0]  i_id_rs;
    logic [4:0]  i_id_rt;
    logic        i_id_wr;
    logic [4:0]  i_id_rd;
    logic        o_stall;
    logic        o_rf_wr;
    logic [4:0]  o_rf_addr;
    logic [31:0] o_rf_data;
    logic        o_err;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending set, FIFO of results, sticky error
    bit          m_pend [32];
    logic [4:0]  m_qa [$];
    logic [31:0] m_qd [$];
    bit          m_err;

    rf_wport_sched #(.FIFO_DEPTH(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .i_wb_wr    (i_wb_wr),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_mc_valid (i_mc_valid),
        .o_mc_ready (o_mc_ready),
        .i_mc_addr  (i_mc_addr),
        .i_mc_data  (i_mc_data),
        .i_iss_valid(i_iss_valid),
        .i_iss_addr (i_iss_addr),
        .i_id_rs    (i_id_rs),
        .i_id_rt    (i_id_rt),
        .i_id_wr    (i_id_wr),
        .i_id_rd    (i_id_rd),
        .o_stall    (o_stall),
        .o_rf_wr    (o_rf_wr),
        .o_rf_addr  (o_rf_addr),
        .o_rf_data  (o_rf_data),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_wb_wr     = 1'b0;
        i_wb_addr   = 5'd0;
        i_wb_data   = 32'd0;
        i_mc_valid  = 1'b0;
        i_mc_addr   = 5'd0;
        i_mc_data   = 32'd0;
        i_iss_valid = 1'b0;
        i_iss_addr  = 5'd0;
        i_id_rs     = 5'd0;
        i_id_rt     = 5'd0;
        i_id_wr     = 1'b0;
        i_id_rd     = 5'd0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_qa.delete();
        m_qd.delete();
        m_err = 1'b0;
    endtask

    function automatic logic model_stall();
        int np;
        np = 0;
        for (int i = 1; i < 32; i++) np += int'(m_pend[i]);
        return ((i_id_rs != 0) && m_pend[i_id_rs])
            || ((i_id_rt != 0) && m_pend[i_id_rt])
            || (i_id_wr && (i_id_rd != 0) && m_pend[i_id_rd])
            || (i_iss_valid && (i_iss_addr != 0) && m_pend[i_iss_addr])
            || (i_iss_valid && ((m_qa.size() + np) >= 2));
    endfunction

    // Called just after a falling edge with inputs driven: check all outputs
    // against the model, advance the model across the rising edge.
    task automatic step();
        logic        e_stall, e_ready, e_wr, wbsel, pop, push, setb, old_pend;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        #1;
        e_stall = model_stall();
        e_ready = (m_qa.size() < 2);
        wbsel   = i_wb_wr && (i_wb_addr != 0);
        if (wbsel) begin
            e_wr = 1'b1; e_addr = i_wb_addr; e_data = i_wb_data;
        end else if (m_qa.size() > 0) begin
            e_wr = 1'b1; e_addr = m_qa[0]; e_data = m_qd[0];
        end else begin
            e_wr = 1'b0; e_addr = 5'd0; e_data = 32'd0;
        end
        check_val("stall",    32'(o_stall),    32'(e_stall));
        check_val("mc_ready", 32'(o_mc_ready), 32'(e_ready));
        check_val("rf_wr",    32'(o_rf_wr),    32'(e_wr));
        check_val("rf_addr",  32'(o_rf_addr),  32'(e_addr));
        check_val("rf_data",  o_rf_data,       e_data);
        check_val("err",      32'(o_err),      32'(m_err));
        pop      = !wbsel && (m_qa.size() > 0);
        push     = i_mc_valid && e_ready && (i_mc_addr != 0);
        setb     = i_iss_valid && !e_stall && (i_iss_addr != 0);
        old_pend = m_pend[i_mc_addr];
        @(posedge clk);
        if (pop) begin
            m_pend[m_qa[0]] = 1'b0;
            void'(m_qa.pop_front());
            void'(m_qd.pop_front());
        end
        if (setb) m_pend[i_iss_addr] = 1'b1;
        if (push) begin
            if (!old_pend) m_err = 1'b1;
            m_qa.push_back(i_mc_addr);
            m_qd.push_back(i_mc_data);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge
    task automatic mid_reset();
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_val("rst_stall", 32'(o_stall),    32'd0);
        check_val("rst_err",   32'(o_err),      32'd0);
        check_val("rst_ready", 32'(o_mc_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic rand_inputs(input int wb_pct);
        int start;
        i_wb_wr     = ($urandom_range(0, 99) < wb_pct);
        i_wb_addr   = 5'($urandom_range(0, 31));
        i_wb_data   = $urandom;
        i_iss_valid = ($urandom_range(0, 99) < 30);
        i_iss_addr  = 5'($urandom_range(0, 31));
        i_id_rs     = 5'($urandom_range(0, 31));
        i_id_rt     = 5'($urandom_range(0, 31));
        i_id_wr     = ($urandom_range(0, 1) == 1);
        i_id_rd     = 5'($urandom_range(0, 31));
        i_mc_valid  = ($urandom_range(0, 99) < 40);
        i_mc_data   = $urandom;
        i_mc_addr   = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 9) != 0) begin
            start = $urandom_range(1, 31);
            for (int k = 0; k < 31; k++) begin
                if (m_pend[((start + k - 1) % 31) + 1]) begin
                    i_mc_addr = 5'(((start + k - 1) % 31) + 1);
                    break;
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        model_clear();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_stall", 32'(o_stall),    32'd0);
        check_val("reset_ready", 32'(o_mc_ready), 32'd1);
        check_val("reset_err",   32'(o_err),      32'd0);
        check_val("reset_rf_wr", 32'(o_rf_wr),    32'd0);
        reset = 1'b1;

        // Issue reg 8, read it in decode, return result 5 cycles later
        i_iss_valid = 1'b1; i_iss_addr = 5'd8; i_id_rs = 5'd8;
        step();
        i_iss_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        i_mc_valid = 1'b1; i_mc_addr = 5'd8; i_mc_data = 32'hDEADBEEF;
        step();
        i_mc_valid = 1'b0;
        #1;
        check_val("t1_stall_wr", 32'(o_stall), 32'd1);
        check_val("t1_rf_addr",  32'(o_rf_addr), 32'd8);
        check_val("t1_rf_data",  o_rf_data, 32'hDEADBEEF);
        step();
        #1 check_val("t1_released", 32'(o_stall), 32'd0);
        step();

        // Port contention: reg 9 buffered while writeback holds the port
        idle_inputs();
        i_iss_valid = 1'b1; i_iss_addr = 5'd9;
        step();
        idle_inputs();
        i_mc_valid = 1'b1; i_mc_addr = 5'd9; i_mc_data = 32'h0000_0009;
        i_wb_wr = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'h0000_0303;
        step();
        i_mc_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check_val("t2_wb_addr", 32'(o_rf_addr), 32'd3);
            step();
        end
        i_wb_wr = 1'b0;
        #1 check_val("t2_mc_addr", 32'(o_rf_addr), 32'd9);
        step();
        step();

        // Back-pressure: regs 4 and 5 buffered under continuous writeback
        idle_inputs();
        i_iss_valid = 1'b1; i_iss_addr = 5'd4; step();
        i_iss_addr = 5'd5; step();
        idle_inputs();
        i_wb_wr = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'h7777_0000;
        i_mc_valid = 1'b1; i_mc_addr = 5'd4; i_mc_data = 32'h4444_4444; step();
        i_mc_addr = 5'd5; i_mc_data = 32'h5555_5555; step();
        i_mc_valid = 1'b0; i_iss_valid = 1'b1; i_iss_addr = 5'd6;
        #1;
        check_val("t3_ready_low", 32'(o_mc_ready), 32'd0);
        check_val("t3_iss_stall", 32'(o_stall), 32'd1);
        step();
        i_iss_valid = 1'b0; i_wb_wr = 1'b0;
        i_id_wr = 1'b1; i_id_rd = 5'd4;
        #1 check_val("t4_waw_stall", 32'(o_stall), 32'd1);
        check_val("t3_drain0", 32'(o_rf_addr), 32'd4);
        step();
        i_id_wr = 1'b0;
        #1 check_val("t3_drain1", 32'(o_rf_addr), 32'd5);
        step();
        #1 check_val("t3_ready_back", 32'(o_mc_ready), 32'd1);

        // $0 handling: no-op issue and dropped result
        idle_inputs();
        i_iss_valid = 1'b1; i_iss_addr = 5'd0;
        #1 check_val("t4_iss0_stall", 32'(o_stall), 32'd0);
        step();
        idle_inputs();
        i_mc_valid = 1'b1; i_mc_addr = 5'd0; i_mc_data = 32'h1234_5678;
        step();
        idle_inputs();
        step();

        // Error: unexpected result for reg 12, then reset mid-drain
        i_mc_valid = 1'b1; i_mc_addr = 5'd12; i_mc_data = 32'h0C0C_0C0C;
        step();
        i_mc_valid = 1'b0;
        #1 check_val("t5_err", 32'(o_err), 32'd1);
        check_val("t5_wr12", 32'(o_rf_addr), 32'd12);
        step();
        i_iss_valid = 1'b1; i_iss_addr = 5'd20; step();
        i_iss_addr = 5'd21; step();
        idle_inputs();
        i_wb_wr = 1'b1; i_wb_addr = 5'd2; i_wb_data = 32'h2;
        i_mc_valid = 1'b1; i_mc_addr = 5'd20; step();
        i_mc_addr = 5'd21; step();
        idle_inputs();
        step();
        mid_reset();
        for (int c = 0; c < 3; c++) step();

        // Randomized traffic in phases of differing writeback load
        for (int c = 0; c < 3000; c++) begin
            rand_inputs((c / 500) % 2 == 0 ? 40 : 85);
            if ((c % 700) == 699) mid_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
